regfile_2r1w: RTL and testbench

Parametrised register file for the RedCPU datapath: two registered read ports, one write port, write-to-read bypass and a per-register pending scoreboard. It supersedes the single-port 16x16 `reg_file`. It sits between decode, which drives the read addresses and marks pending destinations, and writeback, which drives the write port. The scoreboard lets the decode stage stall on read-after-write hazards without keeping a separate tracker.

---
 rtl/rf_pkg.sv | 13 +
 rtl/regfile_2r1w_if.sv | 31 +++
 rtl/regfile_score.sv | 46 ++++
 rtl/regfile_2r1w.sv | 105 ++++++++++
 tb/tb_regfile_2r1w.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the RedCPU register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_DEPTH = 16;

  // True when addr names a real, writable register.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth,
                                   input bit zero_r0);
    return (addr < depth) && !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register file bus: write port, two read ports and pending-mark request.
interface regfile_2r1w_if import rf_pkg::*; #(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned AW    = $clog2(RF_DEPTH)
);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    ra_addr;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             ra_busy;
  logic             rb_busy;
  logic             pend_set;
  logic [AW-1:0]    pend_addr;

  // Decode/writeback side.
  modport master (
    output we, waddr, wdata, ra_addr, rb_addr, pend_set, pend_addr,
    input  ra_data, rb_data, ra_busy, rb_busy
  );

  // Register file side.
  modport slave (
    input  we, waddr, wdata, ra_addr, rb_addr, pend_set, pend_addr,
    output ra_data, rb_data, ra_busy, rb_busy
  );

endinterface

// File: rtl/regfile_score.sv
// Per-register pending scoreboard with two combinational lookups.
module regfile_score import rf_pkg::*; #(
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter bit          ZERO_R0 = 1'b0,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,    // already qualified by the parent
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  output logic          a_busy,
  output logic          b_busy
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // Next pending vector: clear on write, then set overrides (newer producer wins).
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (clr_en && (clr_addr == AW'(i))) pend_d[i] = 1'b0;
      if (set_en && (set_addr == AW'(i)) && addr_ok(i, DEPTH, ZERO_R0)) pend_d[i] = 1'b1;
    end
  end

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Lookups; addresses past DEPTH match nothing and read as not busy.
  always_comb begin
    a_busy = 1'b0;
    b_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a_addr == AW'(i)) a_busy = pend_q[i];
      if (b_addr == AW'(i)) b_busy = pend_q[i];
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Two registered read ports, one write port, write-first bypass, pending scoreboard.
module regfile_2r1w import rf_pkg::*; #(
  parameter int unsigned WIDTH   = RF_WIDTH,
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter bit          ZERO_R0 = 1'b0,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  regfile_2r1w_if.slave bus
);

  // Flop array rather than RAM so reset can clear every entry asynchronously.
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic             wr_ok;
  logic             set_hits_wr;
  logic             byp_a, byp_b;
  logic [WIDTH-1:0] word_a, word_b;
  logic             lk_a_busy, lk_b_busy;

  logic [WIDTH-1:0] ra_data_q, ra_data_d;
  logic [WIDTH-1:0] rb_data_q, rb_data_d;
  logic             ra_busy_q, ra_busy_d;
  logic             rb_busy_q, rb_busy_d;

  assign wr_ok       = bus.we && addr_ok(32'(bus.waddr), DEPTH, ZERO_R0);
  assign set_hits_wr = bus.pend_set && (bus.pend_addr == bus.waddr);
  assign byp_a       = wr_ok && (bus.waddr == bus.ra_addr);
  assign byp_b       = wr_ok && (bus.waddr == bus.rb_addr);

  regfile_score #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0),
    .AW      (AW)
  ) u_score (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.pend_set),
    .set_addr (bus.pend_addr),
    .clr_en   (wr_ok),
    .clr_addr (bus.waddr),
    .a_addr   (bus.ra_addr),
    .b_addr   (bus.rb_addr),
    .a_busy   (lk_a_busy),
    .b_busy   (lk_b_busy)
  );

  // Write decode into the next-state array.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && (bus.waddr == AW'(i))) regs_d[i] = bus.wdata;
    end
  end

  // Storage register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux; out-of-range addresses match nothing and return zero.
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.ra_addr == AW'(i)) word_a = regs_q[i];
      if (bus.rb_addr == AW'(i)) word_b = regs_q[i];
    end
  end

  // Read port next values with write-first bypass; a same-edge set keeps busy high.
  always_comb begin
    ra_data_d = byp_a ? bus.wdata : word_a;
    rb_data_d = byp_b ? bus.wdata : word_b;
    ra_busy_d = byp_a ? set_hits_wr : lk_a_busy;
    rb_busy_d = byp_b ? set_hits_wr : lk_b_busy;
  end

  // Read port output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data_q <= '0;
      rb_data_q <= '0;
      ra_busy_q <= 1'b0;
      rb_busy_q <= 1'b0;
    end else begin
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      ra_busy_q <= ra_busy_d;
      rb_busy_q <= rb_busy_d;
    end
  end

  assign bus.ra_data = ra_data_q;
  assign bus.rb_data = rb_data_q;
  assign bus.ra_busy = ra_busy_q;
  assign bus.rb_busy = rb_busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Default 16x16, ZERO_R0=0
  regfile_2r1w_if #(.WIDTH(16), .AW(4)) bus0 ();
  regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  // 16x16, ZERO_R0=1
  regfile_2r1w_if #(.WIDTH(16), .AW(4)) bus1 ();
  regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  // 12x32, non power-of-two depth
  regfile_2r1w_if #(.WIDTH(32), .AW(4)) bus2 ();
  regfile_2r1w #(.WIDTH(32), .DEPTH(12), .ZERO_R0(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        pset;
    logic [3:0]  paddr;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eabusy;
    logic        ebbusy;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step0(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic ps, input logic [3:0] pa);
    @(negedge clk);
    bus0.we = we; bus0.waddr = wa; bus0.wdata = wd;
    bus0.ra_addr = ra; bus0.rb_addr = rb;
    bus0.pend_set = ps; bus0.pend_addr = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic ps, input logic [3:0] pa);
    @(negedge clk);
    bus1.we = we; bus1.waddr = wa; bus1.wdata = wd;
    bus1.ra_addr = ra; bus1.rb_addr = rb;
    bus1.pend_set = ps; bus1.pend_addr = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic ps, input logic [3:0] pa);
    @(negedge clk);
    bus2.we = we; bus2.waddr = wa; bus2.wdata = wd;
    bus2.ra_addr = ra; bus2.rb_addr = rb;
    bus2.pend_set = ps; bus2.pend_addr = pa;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we, waddr, wdata, ra, rb, pset, paddr, exp A, exp B, busyA, busyB
    vecs[0]  = '{1'b1, 4'd4,  16'hF0F0, 4'd0,  4'd1,  1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  16'h0000, 4'd4,  4'd3,  1'b0, 4'd0,  16'hF0F0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  16'h0000, 4'd4,  4'd4,  1'b0, 4'd0,  16'hF0F0, 16'hF0F0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd7,  16'h1234, 4'd7,  4'd7,  1'b0, 4'd0,  16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd7,  1'b1, 4'd5,  16'h0000, 16'h1234, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  1'b0, 4'd0,  16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'd5,  16'hABCD, 4'd5,  4'd5,  1'b0, 4'd0,  16'hABCD, 16'hABCD, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd7,  1'b0, 4'd0,  16'hABCD, 16'h1234, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd5,  16'h1111, 4'd5,  4'd6,  1'b1, 4'd5,  16'h1111, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd4,  1'b0, 4'd0,  16'h1111, 16'hF0F0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd15, 1'b0, 4'd0,  16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd3,  16'h5555, 4'd3,  4'd15, 1'b1, 4'd15, 16'h5555, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd3,  1'b0, 4'd0,  16'h0000, 16'h5555, 1'b1, 1'b0};

    bus0.we = 0; bus0.waddr = 0; bus0.wdata = 0; bus0.ra_addr = 0; bus0.rb_addr = 0;
    bus0.pend_set = 0; bus0.pend_addr = 0;
    bus1.we = 0; bus1.waddr = 0; bus1.wdata = 0; bus1.ra_addr = 0; bus1.rb_addr = 0;
    bus1.pend_set = 0; bus1.pend_addr = 0;
    bus2.we = 0; bus2.waddr = 0; bus2.wdata = 0; bus2.ra_addr = 0; bus2.rb_addr = 0;
    bus2.pend_set = 0; bus2.pend_addr = 0;

    // Reset pulse strictly between edges
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step0(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0, 4'd0);
      chk($sformatf("reset ra_data[%0d]", i), 32'(bus0.ra_data), 32'h0);
      chk($sformatf("reset rb_data[%0d]", 15 - i), 32'(bus0.rb_data), 32'h0);
      chk($sformatf("reset ra_busy[%0d]", i), 32'(bus0.ra_busy), 32'h0);
      chk($sformatf("reset rb_busy[%0d]", 15 - i), 32'(bus0.rb_busy), 32'h0);
    end

    for (int v = 0; v < 13; v++) begin
      step0(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ra, vecs[v].rb,
            vecs[v].pset, vecs[v].paddr);
      chk($sformatf("vec%0d ra_data", v), 32'(bus0.ra_data), 32'(vecs[v].ea));
      chk($sformatf("vec%0d rb_data", v), 32'(bus0.rb_data), 32'(vecs[v].eb));
      chk($sformatf("vec%0d ra_busy", v), 32'(bus0.ra_busy), 32'(vecs[v].eabusy));
      chk($sformatf("vec%0d rb_busy", v), 32'(bus0.rb_busy), 32'(vecs[v].ebbusy));
    end

    // Mid-sequence reset clears outputs without a clock edge
    step0(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0, 4'd0);
    chk("pre-reset ra_data", 32'(bus0.ra_data), 32'h1111);
    chk("pre-reset ra_busy", 32'(bus0.ra_busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset ra_data", 32'(bus0.ra_data), 32'h0);
    chk("async reset ra_busy", 32'(bus0.ra_busy), 32'h0);
    #1;
    rst_n = 1'b1;
    step0(1'b0, 4'd0, 16'h0, 4'd5, 4'd4, 1'b0, 4'd0);
    chk("post-reset r5 data", 32'(bus0.ra_data), 32'h0);
    chk("post-reset r5 busy", 32'(bus0.ra_busy), 32'h0);
    chk("post-reset r4 data", 32'(bus0.rb_data), 32'h0);

    // ZERO_R0=1: r0 ignores writes and pend_set, no bypass
    step1(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd0);
    chk("z0 bypass ra_data", 32'(bus1.ra_data), 32'h0);
    chk("z0 bypass rb_busy", 32'(bus1.rb_busy), 32'h0);
    step1(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
    chk("z0 r0 data", 32'(bus1.ra_data), 32'h0);
    chk("z0 r0 busy", 32'(bus1.ra_busy), 32'h0);
    step1(1'b1, 4'd1, 16'hFFFF, 4'd1, 4'd0, 1'b0, 4'd0);
    chk("z0 r1 bypass", 32'(bus1.ra_data), 32'hFFFF);
    step1(1'b0, 4'd0, 16'h0, 4'd1, 4'd0, 1'b0, 4'd0);
    chk("z0 r1 data", 32'(bus1.ra_data), 32'hFFFF);
    chk("z0 r0 again", 32'(bus1.rb_data), 32'h0);

    // DEPTH=12, WIDTH=32: out-of-range write and set are dropped
    step2(1'b1, 4'd13, 32'hDEADBEEF, 4'd13, 4'd11, 1'b1, 4'd13);
    chk("d12 oor bypass data", bus2.ra_data, 32'h0);
    chk("d12 oor bypass busy", 32'(bus2.ra_busy), 32'h0);
    step2(1'b0, 4'd0, 32'h0, 4'd13, 4'd11, 1'b0, 4'd0);
    chk("d12 oor data", bus2.ra_data, 32'h0);
    chk("d12 oor busy", 32'(bus2.ra_busy), 32'h0);
    chk("d12 r11 untouched", bus2.rb_data, 32'h0);
    step2(1'b1, 4'd11, 32'hCAFEF00D, 4'd11, 4'd13, 1'b0, 4'd0);
    chk("d12 r11 bypass", bus2.ra_data, 32'hCAFEF00D);
    for (int i = 0; i < 11; i++) begin
      step2(1'b0, 4'd0, 32'h0, 4'(i), 4'd11, 1'b0, 4'd0);
      chk($sformatf("d12 r%0d unchanged", i), bus2.ra_data, 32'h0);
      chk($sformatf("d12 r11 readback %0d", i), bus2.rb_data, 32'hCAFEF00D);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
